// File: rtl/pb8255_pkg.sv
// pb8255_pkg: shared types and constants for the 8255A port B handshake logic.
// Holds the mode-1 strobed-input FSM state type, the port B address decode value,
// the port C bit positions used by port B mode 1, and small helpers around them.
package pb8255_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STROBED,
        FULL
    } pb_state_t;

    localparam logic [1:0] A1A0_PB = 2'b01;

    localparam int PC_INTR_B = 0;
    localparam int PC_IBF_B  = 1;
    localparam int PC_STB_B  = 2;

    // Places the port B handshake signals at their port C bit positions.
    function automatic logic [2:0] pc_bits(input logic intr, input logic ibf, input logic stb_n);
        logic [2:0] v;
        v = '0;
        v[PC_INTR_B] = intr;
        v[PC_IBF_B]  = ibf;
        v[PC_STB_B]  = stb_n;
        return v;
    endfunction

    function automatic logic is_pb_sel(input logic [1:0] a1a0);
        return a1a0 == A1A0_PB;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: STAGES-deep synchroniser followed by a one-flop edge detector.
// Ports:
//   clk     - system clock
//   reset_n - asynchronous active-low reset; every flop resets to RST_VAL
//   din     - input level (asynchronous when STAGES > 0)
//   rise    - one-cycle pulse when the synchronised level goes 0 -> 1
//   fall    - one-cycle pulse when the synchronised level goes 1 -> 0
// STAGES = 0 bypasses the synchroniser for inputs already in the clk domain.
module sync_edge_det #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic sync_q;
    logic prev;

    generate
        if (STAGES == 0) begin : g_bypass
            assign sync_q = din;
        end else begin : g_sync
            logic [STAGES-1:0] chain;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    chain <= {STAGES{RST_VAL}};
                end else begin
                    chain[0] <= din;
                    for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
                end
            end
            assign sync_q = chain[STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev <= RST_VAL;
        else          prev <= sync_q;
    end

    assign rise = sync_q & ~prev;
    assign fall = ~sync_q & prev;

endmodule

// File: rtl/pb_strobe_in_ctrl.sv
// pb_strobe_in_ctrl: 8255A port B mode-1 strobed-input handshake controller.
// Ports:
//   clk, reset_n       - system clock, asynchronous active-low reset
//   mode1              - 1 = strobed input (mode 1), 0 = plain sampling (mode 0)
//   inte_set, inte_clr - one-cycle pulses setting/clearing INTE_B (clear wins)
//   stb_n              - asynchronous peripheral strobe, active low
//   pb_pins            - port B pins
//   rd_pb              - high while the CPU read of port B is active
//   pb_data, pb_ld     - captured data and its one-cycle update pulse
//   ibf, intr, inte    - input buffer full, interrupt request B, INTE_B state
//   overrun            - sticky: a strobe arrived while the buffer was full
module pb_strobe_in_ctrl
    import pb8255_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mode1,
    input  logic              inte_set,
    input  logic              inte_clr,
    input  logic              stb_n,
    input  logic [DATA_W-1:0] pb_pins,
    input  logic              rd_pb,
    output logic [DATA_W-1:0] pb_data,
    output logic              pb_ld,
    output logic              ibf,
    output logic              intr,
    output logic              inte,
    output logic              overrun
);

    logic stb_rise, stb_fall, rd_rise, rd_fall;

    sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_stb (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (stb_n),
        .rise    (stb_rise),
        .fall    (stb_fall)
    );

    // rd_pb is already synchronous to clk, so only the edge detector is kept.
    sync_edge_det #(.STAGES(0), .RST_VAL(1'b0)) u_rd (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (rd_pb),
        .rise    (rd_rise),
        .fall    (rd_fall)
    );

    pb_state_t state, state_nxt;
    logic inte_q, inte_nxt, intr_q, intr_nxt, ovr_q, ovr_nxt;
    logic capture, release_ev, read_done;

    always_comb begin
        capture    = mode1 && state == IDLE && stb_fall;
        release_ev = state == STROBED && stb_rise;
        read_done  = state == FULL && rd_fall;
        state_nxt  = !mode1     ? IDLE :
                     capture    ? STROBED :
                     release_ev ? FULL :
                     read_done  ? IDLE : state;
        inte_nxt   = ~inte_clr & (inte_q | inte_set);
        // Gating with the next INTE value drops intr on the same edge INTE clears.
        intr_nxt   = mode1 & inte_nxt & ~rd_rise & (intr_q | release_ev);
        ovr_nxt    = mode1 & ~read_done & (ovr_q | (state != IDLE && stb_fall));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            inte_q  <= 1'b0;
            intr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            pb_ld   <= 1'b0;
            pb_data <= '0;
        end else begin
            state  <= state_nxt;
            inte_q <= inte_nxt;
            intr_q <= intr_nxt;
            ovr_q  <= ovr_nxt;
            pb_ld  <= !mode1 || capture;
            if (!mode1 || capture) pb_data <= pb_pins;
        end
    end

    assign ibf     = state != IDLE;
    assign intr    = intr_q;
    assign inte    = inte_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_pb_strobe_in_ctrl.sv
// tb_pb_strobe_in_ctrl: self-checking bench for pb_strobe_in_ctrl (directed table,
// hand-written disruption sequences, and random traffic against a flag-level model).
module tb_pb_strobe_in_ctrl;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       mode1 = 1'b0, inte_set = 1'b0, inte_clr = 1'b0;
    logic       stb_n = 1'b1, rd_pb = 1'b0;
    logic [7:0] pb_pins = 8'h00;
    logic [7:0] pb_data;
    logic       pb_ld, ibf, intr, inte, overrun;

    int total = 0;
    int bad = 0;

    pb_strobe_in_ctrl #(.SYNC_STAGES(SYNC), .DATA_W(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .mode1    (mode1),
        .inte_set (inte_set),
        .inte_clr (inte_clr),
        .stb_n    (stb_n),
        .pb_pins  (pb_pins),
        .rd_pb    (rd_pb),
        .pb_data  (pb_data),
        .pb_ld    (pb_ld),
        .ibf      (ibf),
        .intr     (intr),
        .inte     (inte),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       m, s, c, stb;
        logic [7:0] pins;
        logic       rd;
        logic [7:0] d;
        logic       ld, ibf, intr, inte, ovr;
    } vec_t;

    vec_t tbl[$];

    task automatic rowsn(input int n, input logic m, s, c, stb, input logic [7:0] pins,
                         input logic rd, input logic [7:0] d, input logic ld, fb, ir, ie, ov);
        vec_t v;
        v.m = m; v.s = s; v.c = c; v.stb = stb; v.pins = pins; v.rd = rd;
        v.d = d; v.ld = ld; v.ibf = fb; v.intr = ir; v.inte = ie; v.ovr = ov;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endtask

    function automatic logic [12:0] obs();
        return {pb_data, pb_ld, ibf, intr, inte, overrun};
    endfunction

    task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {data,ld,ibf,intr,inte,ovr}=%h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Behavioural model: synchronised strobe is the pin value seen SYNC edges back;
    // the handshake is tracked as "buffer full" and "strobe released" flags.
    logic [7:0] md;
    logic       mld, mfull, mrel, mintr, minte, movr, sprev, rprev;
    logic       q[$];

    task automatic m_reset();
        md = 8'h00; mld = 0; mfull = 0; mrel = 0; mintr = 0; minte = 0; movr = 0;
        q = {};
        for (int k = 0; k < SYNC; k++) q.push_back(1'b1);
        sprev = 1'b1;
        rprev = 1'b0;
    endtask

    task automatic m_step();
        logic s, fall, rise, rf, rr, ni, full0, rel0;
        s = q[0];
        fall = sprev & ~s;
        rise = ~sprev & s;
        sprev = s;
        void'(q.pop_front());
        q.push_back(stb_n);
        rf = rprev & ~rd_pb;
        rr = ~rprev & rd_pb;
        rprev = rd_pb;
        ni = inte_clr ? 1'b0 : inte_set ? 1'b1 : minte;
        full0 = mfull;
        rel0 = mrel;
        if (!mode1) begin
            md = pb_pins; mld = 1; mfull = 0; mrel = 0; mintr = 0; movr = 0;
        end else begin
            mld = 0;
            if (full0 && rel0 && rf) begin
                mfull = 0; movr = 0;
            end else if (full0 && fall) begin
                movr = 1;
            end else if (!full0 && fall) begin
                md = pb_pins; mld = 1; mfull = 1; mrel = 0;
            end
            if (full0 && !rel0 && rise) begin
                mrel = 1;
                if (ni) mintr = 1;
            end
        end
        if (rr || !ni) mintr = 0;
        minte = ni;
    endtask

    initial begin
        //     n  m s c stb pins   rd  data  ld ibf intr inte ovr
        rowsn(2, 0,0,0,1, 8'h3C,0, 8'h3C, 1,0,0,0,0);
        rowsn(1, 1,1,0,1, 8'hA5,0, 8'h3C, 0,0,0,1,0);
        rowsn(2, 1,0,0,0, 8'hA5,0, 8'h3C, 0,0,0,1,0);
        rowsn(1, 1,0,0,0, 8'hA5,0, 8'hA5, 1,1,0,1,0);
        rowsn(1, 1,0,0,0, 8'hA5,0, 8'hA5, 0,1,0,1,0);
        rowsn(2, 1,0,0,1, 8'hA5,0, 8'hA5, 0,1,0,1,0);
        rowsn(1, 1,0,0,1, 8'hA5,0, 8'hA5, 0,1,1,1,0);
        rowsn(1, 1,0,0,1, 8'hA5,1, 8'hA5, 0,1,0,1,0);
        rowsn(1, 1,0,0,1, 8'hA5,0, 8'hA5, 0,0,0,1,0);
        rowsn(1, 1,0,1,1, 8'h5A,0, 8'hA5, 0,0,0,0,0);
        rowsn(2, 1,0,0,0, 8'h5A,0, 8'hA5, 0,0,0,0,0);
        rowsn(1, 1,0,0,0, 8'h5A,0, 8'h5A, 1,1,0,0,0);
        rowsn(1, 1,0,0,0, 8'h5A,0, 8'h5A, 0,1,0,0,0);
        rowsn(3, 1,0,0,1, 8'h5A,0, 8'h5A, 0,1,0,0,0);
        rowsn(1, 1,0,0,1, 8'h5A,1, 8'h5A, 0,1,0,0,0);
        rowsn(1, 1,0,0,1, 8'h5A,0, 8'h5A, 0,0,0,0,0);
        rowsn(2, 1,0,0,0, 8'h11,0, 8'h5A, 0,0,0,0,0);
        rowsn(1, 1,0,0,0, 8'h11,0, 8'h11, 1,1,0,0,0);
        rowsn(1, 1,0,0,0, 8'h11,0, 8'h11, 0,1,0,0,0);
        rowsn(3, 1,0,0,1, 8'h11,0, 8'h11, 0,1,0,0,0);
        rowsn(2, 1,0,0,0, 8'h22,0, 8'h11, 0,1,0,0,0);
        rowsn(2, 1,0,0,0, 8'h22,0, 8'h11, 0,1,0,0,1);
        rowsn(3, 1,0,0,1, 8'h22,0, 8'h11, 0,1,0,0,1);
        rowsn(1, 1,0,0,1, 8'h22,1, 8'h11, 0,1,0,0,1);
        rowsn(1, 1,0,0,1, 8'h22,0, 8'h11, 0,0,0,0,0);
        rowsn(1, 1,1,1,1, 8'h22,0, 8'h11, 0,0,0,0,0);
        rowsn(1, 1,1,0,1, 8'h22,0, 8'h11, 0,0,0,1,0);
        rowsn(2, 1,0,0,0, 8'h77,0, 8'h11, 0,0,0,1,0);
        rowsn(1, 1,0,0,0, 8'h77,0, 8'h77, 1,1,0,1,0);
        rowsn(1, 1,0,0,0, 8'h77,0, 8'h77, 0,1,0,1,0);
        rowsn(2, 1,0,0,1, 8'h77,0, 8'h77, 0,1,0,1,0);
        rowsn(1, 1,0,0,1, 8'h77,0, 8'h77, 0,1,1,1,0);
        rowsn(1, 1,0,1,1, 8'h77,0, 8'h77, 0,1,0,0,0);
        rowsn(1, 1,1,0,1, 8'h77,0, 8'h77, 0,1,0,1,0);
        rowsn(1, 1,0,0,1, 8'h77,1, 8'h77, 0,1,0,1,0);
        rowsn(1, 1,0,0,1, 8'h77,0, 8'h77, 0,0,0,1,0);
        rowsn(2, 1,0,0,0, 8'h99,0, 8'h77, 0,0,0,1,0);
        rowsn(1, 1,0,0,0, 8'h99,0, 8'h99, 1,1,0,1,0);
        rowsn(1, 1,0,0,0, 8'h99,1, 8'h99, 0,1,0,1,0);
        rowsn(1, 1,0,0,0, 8'h99,0, 8'h99, 0,1,0,1,0);

        repeat (2) @(negedge clk);
        chk("reset_state", obs(), 13'h0);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            mode1 = tbl[i].m; inte_set = tbl[i].s; inte_clr = tbl[i].c;
            stb_n = tbl[i].stb; pb_pins = tbl[i].pins; rd_pb = tbl[i].rd;
            cyc();
            chk($sformatf("row%0d", i), obs(),
                {tbl[i].d, tbl[i].ld, tbl[i].ibf, tbl[i].intr, tbl[i].inte, tbl[i].ovr});
        end

        // Reset while STROBED: flags drop without waiting for a clock edge.
        reset_n = 1'b0;
        #1;
        chk("async_reset", obs(), 13'h0);
        stb_n = 1'b1; rd_pb = 1'b0; inte_set = 1'b0; inte_clr = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // First strobe after reset is a fresh capture; then overrun, then mode 1 -> 0 in FULL.
        mode1 = 1'b1; inte_set = 1'b1; pb_pins = 8'h42;
        cyc();
        inte_set = 1'b0; stb_n = 1'b0;
        repeat (4) cyc();
        stb_n = 1'b1;
        repeat (3) cyc();
        chk("fresh_capture", obs(), {8'h42, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
        pb_pins = 8'h24; stb_n = 1'b0;
        repeat (3) cyc();
        chk("overrun_full", obs(), {8'h42, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1});
        stb_n = 1'b1;
        repeat (3) cyc();
        mode1 = 1'b0; pb_pins = 8'hE7;
        cyc();
        chk("mode_drop", obs(), {8'hE7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        pb_pins = 8'h81;
        cyc();
        chk("mode0_track", obs(), {8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});

        // Random traffic against the model.
        reset_n = 1'b0;
        stb_n = 1'b1; rd_pb = 1'b0; mode1 = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        m_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 4) == 0) stb_n = ~stb_n;
            if ($urandom_range(0, 5) == 0) rd_pb = ~rd_pb;
            inte_set = ($urandom_range(0, 19) == 0);
            inte_clr = ($urandom_range(0, 29) == 0);
            mode1 = ($urandom_range(0, 199) != 0);
            pb_pins = 8'($urandom);
            @(posedge clk);
            m_step();
            @(negedge clk);
            chk($sformatf("rand%0d", i), obs(), {md, mld, mfull, mintr, minte, movr});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
